// File: rtl/mem_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_stage : passes ALU results through; runs loads/stores byte-serially
//             on the shared 8-bit RAM port while requesting a pipeline stall.
// Rev 1.0
// ----------------------------------------------------------------------------
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_write_data_i,
  input  logic        mem_rw_i,
  input  logic [7:0]  aluop_i,
  input  logic [4:0]  lock_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        stall_req_o,
  output logic        ram_req_o,
  input  logic        ram_grant_i,
  output logic [31:0] ram_addr_o,
  output logic        ram_we_o,
  output logic [7:0]  ram_data_o,
  input  logic [7:0]  ram_data_i
);

  localparam logic [7:0] c_EXE_LB_OP  = 8'h20;
  localparam logic [7:0] c_EXE_LH_OP  = 8'h21;
  localparam logic [7:0] c_EXE_LW_OP  = 8'h22;
  localparam logic [7:0] c_EXE_LBU_OP = 8'h23;
  localparam logic [7:0] c_EXE_LHU_OP = 8'h24;
  localparam logic [7:0] c_EXE_SB_OP  = 8'h25;
  localparam logic [7:0] c_EXE_SH_OP  = 8'h26;
  localparam logic [7:0] c_EXE_SW_OP  = 8'h27;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_cnt;
  logic [31:0] r_buf;
  logic        r_rd_pend;
  logic [1:0]  r_rd_idx;

  logic        w_is_mem;
  logic [1:0]  w_last;
  logic        w_issue;
  logic [31:0] w_load_data;
  logic        w_stall;
  logic        w_req;
  logic        w_we;
  logic        w_wreg;
  logic [31:0] w_wdata;
  logic        w_unused;

  assign w_unused = ^{lock_i[4], lock_i[2:0]};

  // Operation decode: w_last is the index of the final byte (N-1).
  always_comb begin
    w_is_mem = 1'b1;
    w_last   = 2'd0;
    case (aluop_i)
      c_EXE_LB_OP, c_EXE_LBU_OP, c_EXE_SB_OP: w_last = 2'd0;
      c_EXE_LH_OP, c_EXE_LHU_OP, c_EXE_SH_OP: w_last = 2'd1;
      c_EXE_LW_OP, c_EXE_SW_OP:               w_last = 2'd3;
      default:                                w_is_mem = 1'b0;
    endcase
  end

  always_comb begin
    case (aluop_i)
      c_EXE_LB_OP:  w_load_data = {{24{r_buf[7]}}, r_buf[7:0]};
      c_EXE_LBU_OP: w_load_data = {24'd0, r_buf[7:0]};
      c_EXE_LH_OP:  w_load_data = {{16{r_buf[15]}}, r_buf[15:0]};
      c_EXE_LHU_OP: w_load_data = {16'd0, r_buf[15:0]};
      default:      w_load_data = r_buf;
    endcase
  end

  assign w_issue = (r_state == S_ACCESS) && ram_grant_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 2'd0;
      r_buf     <= 32'd0;
      r_rd_pend <= 1'b0;
      r_rd_idx  <= 2'd0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE) begin
        r_cnt <= 2'd0;
      end else if (w_issue) begin
        r_cnt <= r_cnt + 2'd1;
      end
      // Read data returns one cycle after its address, so remember which byte.
      r_rd_pend <= w_issue && !mem_rw_i;
      r_rd_idx  <= r_cnt;
      if (r_rd_pend) begin
        r_buf[{r_rd_idx, 3'b000} +: 8] <= ram_data_i;
      end
    end
  end

  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    w_req   = 1'b0;
    w_we    = 1'b0;
    w_wreg  = wreg_i;
    w_wdata = wdata_i;
    case (r_state)
      S_IDLE: begin
        if (w_is_mem) begin
          w_stall = 1'b1;
          w_wreg  = 1'b0;
          w_next  = S_ACCESS;
        end
      end
      S_ACCESS: begin
        w_stall = 1'b1;
        w_wreg  = 1'b0;
        w_req   = 1'b1;
        w_we    = mem_rw_i && ram_grant_i;
        if (w_issue && (r_cnt == w_last)) begin
          w_next = mem_rw_i ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        w_stall = 1'b1;
        w_wreg  = 1'b0;
        w_next  = S_DONE;
      end
      S_DONE: begin
        w_wdata = mem_rw_i ? wdata_i : w_load_data;
        // Leave only when the next instruction is clocked in.
        if (!lock_i[3]) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Every output is forced low while reset is asserted, including pass-through.
  assign wd_o        = rst ? wd_i : 5'd0;
  assign wreg_o      = rst && w_wreg;
  assign wdata_o     = rst ? w_wdata : 32'd0;
  assign stall_req_o = rst && w_stall;
  assign ram_req_o   = rst && w_req;
  assign ram_we_o    = rst && w_we;
  assign ram_addr_o  = (rst && w_req) ? (mem_addr_i + {30'd0, r_cnt}) : 32'd0;
  assign ram_data_o  = (rst && w_req) ? mem_write_data_i[{r_cnt, 3'b000} +: 8] : 8'd0;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// Directed testbench for mem_stage with a byte-wide RAM responder.
module tb_mem_stage;

  localparam logic [7:0] c_LB  = 8'h20;
  localparam logic [7:0] c_LH  = 8'h21;
  localparam logic [7:0] c_LW  = 8'h22;
  localparam logic [7:0] c_LBU = 8'h23;
  localparam logic [7:0] c_SW  = 8'h27;
  localparam logic [7:0] c_NOP = 8'h01;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_write_data_i;
  logic        mem_rw_i;
  logic [7:0]  aluop_i;
  logic [4:0]  lock_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stall_req_o;
  logic        ram_req_o;
  logic        ram_grant_i;
  logic [31:0] ram_addr_o;
  logic        ram_we_o;
  logic [7:0]  ram_data_o;
  logic [7:0]  ram_data_i = 8'd0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst(rst),
    .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .mem_addr_i(mem_addr_i), .mem_write_data_i(mem_write_data_i),
    .mem_rw_i(mem_rw_i), .aluop_i(aluop_i), .lock_i(lock_i),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .stall_req_o(stall_req_o), .ram_req_o(ram_req_o), .ram_grant_i(ram_grant_i),
    .ram_addr_o(ram_addr_o), .ram_we_o(ram_we_o), .ram_data_o(ram_data_o),
    .ram_data_i(ram_data_i)
  );

  // RAM model: preloaded once, logs every granted write and read.
  logic [7:0]  mem [0:1023];
  logic        init_done = 1'b0;
  logic [31:0] wlog_a[$];
  logic [7:0]  wlog_d[$];
  logic [31:0] rlog[$];

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'd0;
      mem[10'h020] <= 8'h80;
      mem[10'h040] <= 8'h34; mem[10'h041] <= 8'h92;
      mem[10'h060] <= 8'h78; mem[10'h061] <= 8'h56;
      mem[10'h062] <= 8'h34; mem[10'h063] <= 8'h12;
      init_done <= 1'b1;
    end else if (ram_req_o && ram_grant_i) begin
      if (ram_we_o) begin
        mem[ram_addr_o[9:0]] <= ram_data_o;
        wlog_a.push_back(ram_addr_o);
        wlog_d.push_back(ram_data_o);
      end else begin
        ram_data_i <= mem[ram_addr_o[9:0]];
        rlog.push_back(ram_addr_o);
      end
    end
  end

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Apply one memory op, follow it to DONE, check latency and result.
  task automatic do_op(input string tag, input logic [7:0] op, input logic rw,
                       input logic [31:0] addr, input logic [31:0] sdata,
                       input logic [31:0] gaps, input int hold,
                       input logic [31:0] exp_w, input int exp_t);
    int t;
    int wreg_err;
    int nw;
    @(negedge clk);
    aluop_i = op; mem_rw_i = rw; mem_addr_i = addr; mem_write_data_i = sdata;
    wd_i = 5'd9; wreg_i = 1'b1; wdata_i = 32'h0BAD_F00D; lock_i = 5'd0;
    t = 0; wreg_err = 0;
    ram_grant_i = ~gaps[0];
    #1;
    while (stall_req_o && t < 40) begin
      if (wreg_o) wreg_err++;
      @(negedge clk);
      t++;
      ram_grant_i = (t < 32) ? ~gaps[t] : 1'b1;
      #1;
    end
    ram_grant_i = 1'b1;
    chk({tag, "_lat"}, t, exp_t);
    chk({tag, "_wreg_stall"}, wreg_err, 0);
    chk({tag, "_wdata"}, wdata_o, exp_w);
    chk({tag, "_done"}, {ram_req_o, wreg_o, wd_o}, {1'b0, 1'b1, 5'd9});
    if (hold > 0) begin
      lock_i = 5'b01000;
      nw = wlog_a.size();
      repeat (hold) begin
        @(negedge clk);
        #1;
      end
      chk({tag, "_hold_state"}, {stall_req_o, ram_req_o, wreg_o, wdata_o},
          {1'b0, 1'b0, 1'b1, exp_w});
      chk({tag, "_hold_writes"}, wlog_a.size(), nw);
      lock_i = 5'd0;
    end
    @(negedge clk);
    aluop_i = c_NOP;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n0;
    rst = 1'b0; lock_i = 5'd0; ram_grant_i = 1'b1;
    wd_i = 5'd5; wreg_i = 1'b1; wdata_i = 32'h55;
    aluop_i = c_SW; mem_rw_i = 1'b1; mem_addr_i = 32'h100; mem_write_data_i = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ctrl", {stall_req_o, ram_req_o, ram_we_o, wreg_o}, 4'd0);
    chk("rst_wd", wd_o, 0);
    chk("rst_wdata", wdata_o, 0);
    chk("rst_addr", ram_addr_o, 0);

    @(negedge clk);
    aluop_i = c_NOP; mem_rw_i = 1'b0; rst = 1'b1;
    @(negedge clk);
    wd_i = 5'd5; wreg_i = 1'b1; wdata_i = 32'h55;
    #1;
    chk("nop_pass", {wd_o, wreg_o, wdata_o}, {5'd5, 1'b1, 32'h55});
    chk("nop_ctrl", {stall_req_o, ram_req_o, ram_we_o}, 3'd0);

    n0 = wlog_a.size();
    do_op("sw", c_SW, 1'b1, 32'h100, 32'hA1B2C3D4, 32'd0, 0, 32'h0BAD_F00D, 5);
    chk("sw_nwr", wlog_a.size() - n0, 4);
    if (wlog_a.size() - n0 == 4) begin
      chk("sw_b0", {wlog_a[n0],   wlog_d[n0]},   {32'h100, 8'hD4});
      chk("sw_b1", {wlog_a[n0+1], wlog_d[n0+1]}, {32'h101, 8'hC3});
      chk("sw_b2", {wlog_a[n0+2], wlog_d[n0+2]}, {32'h102, 8'hB2});
      chk("sw_b3", {wlog_a[n0+3], wlog_d[n0+3]}, {32'h103, 8'hA1});
    end

    do_op("lb",  c_LB,  1'b0, 32'h20, 32'd0, 32'd0, 0, 32'hFFFF_FF80, 3);
    do_op("lbu", c_LBU, 1'b0, 32'h20, 32'd0, 32'd0, 0, 32'h0000_0080, 3);
    do_op("lh",  c_LH,  1'b0, 32'h40, 32'd0, 32'd0, 0, 32'hFFFF_9234, 4);
    do_op("lw",  c_LW,  1'b0, 32'h60, 32'd0, 32'd0, 0, 32'h1234_5678, 6);

    n0 = rlog.size();
    do_op("lw_gap", c_LW, 1'b0, 32'h60, 32'd0, 32'h0000_000C, 0, 32'h1234_5678, 8);
    chk("gap_nrd", rlog.size() - n0, 4);
    if (rlog.size() - n0 == 4) begin
      for (int k = 0; k < 4; k++) chk("gap_addr", rlog[n0+k], 32'h60 + k);
    end

    n0 = wlog_a.size();
    do_op("sw_hold", c_SW, 1'b1, 32'h300, 32'hCAFE_F00D, 32'd0, 3, 32'h0BAD_F00D, 5);
    chk("hold_nwr", wlog_a.size() - n0, 4);
    chk("hold_mem", {mem[10'h303], mem[10'h302], mem[10'h301], mem[10'h300]}, 32'hCAFE_F00D);

    // Abort a store after two bytes have been written.
    n0 = wlog_a.size();
    @(negedge clk);
    aluop_i = c_SW; mem_rw_i = 1'b1; mem_addr_i = 32'h200; mem_write_data_i = 32'h1122_3344;
    wd_i = 5'd9; wreg_i = 1'b1; ram_grant_i = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("abort_pre_we", ram_we_o, 1'b1);
    rst = 1'b0;
    #1;
    chk("abort_ctrl", {stall_req_o, ram_req_o, ram_we_o, wreg_o}, 4'd0);
    chk("abort_data", {wd_o, wdata_o}, 37'd0);
    @(negedge clk);
    aluop_i = c_NOP; mem_rw_i = 1'b0; rst = 1'b1;
    @(negedge clk);
    #1;
    chk("post_rst", {stall_req_o, ram_req_o, ram_we_o}, 3'd0);
    repeat (2) @(negedge clk);
    chk("abort_nwr", wlog_a.size() - n0, 2);
    chk("abort_mem", {mem[10'h203], mem[10'h202], mem[10'h201], mem[10'h200]}, 32'h0000_3344);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_stage.md
# mem_stage

Memory-access stage between the EX/MEM pipeline register and the MEM/WB register of the RISC-V core. It passes ALU results through unchanged and executes loads and stores as multi-cycle byte-serial transactions on the shared 8-bit RAM port. While an access is in progress it raises a stall request toward the pipeline controller.

## Interface
Parameters:
- none; widths come from `defines.v` (`RegAddrBus` 5, `RegBus` 32, `RamAddrBus`, `AluOpBus`).

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- wd_i  in  `RegAddrBus`  destination register from EX/MEM
- wreg_i  in  1  write-enable from EX/MEM
- wdata_i  in  `RegBus`  ALU result from EX/MEM
- mem_addr_i  in  `RamAddrBus`  byte address of the load/store
- mem_write_data_i  in  `RegBus`  store data
- mem_rw_i  in  1  1 = store, 0 = load; meaningful only for memory ops
- aluop_i  in  `AluOpBus`  operation; memory ops are `EXE_LB/LH/LW/LBU/LHU/SB/SH/SW_OP`
- lock_i  in  5  pipeline hold vector; bit 3 = EX/MEM holding
- wd_o  out  `RegAddrBus`  to MEM/WB
- wreg_o  out  1  to MEM/WB
- wdata_o  out  `RegBus`  to MEM/WB
- stall_req_o  out  1  stall request to controller
- ram_req_o  out  1  RAM port request to arbiter
- ram_grant_i  in  1  arbiter grant, same-cycle
- ram_addr_o  out  `RamAddrBus`  byte address
- ram_we_o  out  1  1 = write this cycle
- ram_data_o  out  8  write byte
- ram_data_i  in  8  read byte, valid one cycle after the address cycle

## Operation
- Byte count N: B/BU = 1, H/HU = 2, W = 4. Little-endian; byte k uses address mem_addr_i+k, wrapping modulo the `RamAddrBus` width. No alignment check.
- Non-memory aluop: outputs are combinational pass-through of wd_i/wreg_i/wdata_i; stall_req_o=0; ram_req_o=0.
- FSM states: IDLE, ACCESS, WAIT (loads only), DONE. Byte counter cnt is 0..3.
- IDLE: when a memory op is present, stall_req_o=1 and wreg_o=0; next state is ACCESS with cnt=0.
- ACCESS: ram_req_o=1, ram_addr_o=mem_addr_i+cnt, ram_we_o=mem_rw_i, ram_data_o=mem_write_data_i[8cnt+:8].
  - A byte is issued only in a cycle with ram_grant_i=1; cnt increments only on an issued byte.
  - After byte N-1 issues: a store goes to DONE, a load goes to WAIT.
- Load capture: a 1-bit flag records "read issued last cycle". When it is set, ram_data_i is written to buf[8j+:8], where j is the index issued the previous cycle. WAIT captures the final byte and then goes to DONE.
- DONE: stall_req_o=0, ram_req_o=0, wd_o=wd_i, wreg_o=wreg_i.
  - Load wdata_o: LB/LH sign-extend buf[7]/buf[15]; LBU/LHU zero-extend; LW uses buf.
  - Store wdata_o = wdata_i.
  - DONE returns to IDLE on an edge with lock_i[3]=0, which is when the next instruction enters. While lock_i[3]=1, DONE holds and issues no RAM traffic, so the access is never repeated.
- stall_req_o=1 in IDLE-with-memory-op, ACCESS and WAIT. wreg_o=0 whenever stall_req_o=1.

## Timing
- Reset (rst=0, asynchronous): state IDLE, cnt 0, buf 0, flag 0. All outputs 0 while rst=0.
- Load latency with continuous grant: T0 IDLE, T1..TN issue, T(N+1) WAIT, T(N+2) DONE with result valid. LW takes 6 cycles.
- Store latency: T0 IDLE, T1..TN write, T(N+1) DONE. SW takes 5 cycles.
- Grant low in ACCESS: no address is issued and ram_we_o=0; cnt and buf hold; the latency stretches by one cycle per denied cycle.
- Reset asserted mid-access: abort immediately. ram_we_o drops asynchronously; no further bytes are written; the partial store is left in RAM.
- Back-to-back memory ops: DONE→IDLE on the lock_i[3]=0 edge. The new op starts in IDLE in the following cycle with a fresh stall.

## Test plan
- Reset: rst=0 mid-ACCESS of SW -> all outputs 0 within the same cycle; after release, state IDLE and no write strobe.
- SW addr 0x100, data 0xA1B2C3D4, grant=1 -> writes 0xD4@0x100, 0xC3@0x101, 0xB2@0x102, 0xA1@0x103 in T1..T4; stall high T0..T4; DONE at T5.
- LB addr 0x20, RAM byte 0x80 -> wdata_o=0xFFFFFF80 in DONE at T3. LBU with the same data -> 0x00000080.
- LH addr 0x40, bytes 0x34,0x92 -> wdata_o=0xFFFF9234. LW bytes 0x78,0x56,0x34,0x12 -> 0x12345678 at T6.
- LW with grant low at T2 and T3 -> the same 4 addresses issue in order, no byte is skipped or duplicated, DONE at T8, result correct.
- Non-memory op (wd=5, wreg=1, wdata=0x55) -> same-cycle pass-through, stall 0. SW held in DONE with lock_i[3]=1 for 3 cycles -> no extra RAM writes.
